ex_stage_ctrl: RTL and testbench

//  Parametrised EX-stage control unit for the 3-stage MIPS pipeline (FETCH/EX/WB).

---
 rtl/ex_stage_ctrl.sv | 169 ++++++++++++++++
 tb/tb_ex_stage_ctrl.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage_ctrl.sv
// EX-stage control for the 3-stage MIPS pipeline (FETCH/EX/WB).
// Decodes instruction_EX into ALU, regfile, HI/LO and GPIO controls. It also
// squashes the shadow slots after a taken branch and interlocks HI/LO readers
// while a multiply is in flight.
// Optional feature: define EX_CTRL_JUMP_EN to decode j / jal / jr.
module ex_stage_ctrl #(
    parameter int MULT_LATENCY  = 4,
    parameter int BRANCH_SHADOW = 1,
    parameter int ALU_OP_W      = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                valid_EX,
    input  logic [31:0]         instruction_EX,
    input  logic                zero_EX,
    output logic [ALU_OP_W-1:0] op_EX,
    output logic [4:0]          shamt_EX,
    output logic [1:0]          alu_src_EX,
    output logic                rdrt_EX,
    output logic [1:0]          regsel_EX,
    output logic                regwrite_EX,
    output logic                enhilo_EX,
    output logic [1:0]          pc_src_EX,
    output logic                stall_FETCH,
    output logic                gpio_we,
    output logic                hilo_busy
);

    localparam logic [ALU_OP_W-1:0] ALU_ADD = ALU_OP_W'(4'b0100);
    localparam logic [ALU_OP_W-1:0] ALU_SUB = ALU_OP_W'(4'b0101);
    localparam logic [ALU_OP_W-1:0] ALU_OR  = ALU_OP_W'(4'b0001);
    localparam logic [ALU_OP_W-1:0] ALU_SLL = ALU_OP_W'(4'b1000);

    localparam logic [5:0] OPC_SPECIAL = 6'b000000;
    localparam logic [5:0] OPC_ADDI    = 6'b001000;
    localparam logic [5:0] OPC_ADDIU   = 6'b001001;
    localparam logic [5:0] OPC_LUI     = 6'b001111;
    localparam logic [5:0] OPC_ORI     = 6'b001101;
    localparam logic [5:0] OPC_BNE     = 6'b000101;
`ifdef EX_CTRL_JUMP_EN
    localparam logic [5:0] OPC_J       = 6'b000010;
    localparam logic [5:0] OPC_JAL     = 6'b000011;
    localparam logic [5:0] FN_JR       = 6'b001000;
`endif

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_SRL   = 6'b000010;

    // The issuing cycle counts as the first of MULT_LATENCY, so readers are
    // held for MULT_LATENCY-1 cycles and issue exactly MULT_LATENCY after the mult.
    localparam logic [3:0] BUSY_LOAD   = 4'(MULT_LATENCY - 1);
    localparam logic [1:0] SHADOW_LOAD = 2'(BRANCH_SHADOW);

    logic [3:0] busy_cnt, busy_nxt;
    logic [1:0] squash_cnt, squash_nxt;
    logic [5:0] opcode, funct;
    logic [4:0] shamt_field;
    logic       decode_en;
    logic       unused_fields;

    assign opcode        = instruction_EX[31:26];
    assign funct         = instruction_EX[5:0];
    assign shamt_field   = instruction_EX[10:6];
    assign unused_fields = ^instruction_EX[25:11];
    assign hilo_busy     = (busy_cnt != 4'd0);
    assign decode_en     = rst_n && valid_EX && (squash_cnt == 2'd0);

    // Hazard counters: squash slots remaining and multiply cycles remaining.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            squash_cnt <= 2'd0;
            busy_cnt   <= 4'd0;
        end else begin
            squash_cnt <= squash_nxt;
            busy_cnt   <= busy_nxt;
        end
    end

    // Decode, interlock and squash control; reset forces every output to default.
    always_comb begin
        op_EX       = ALU_ADD;
        shamt_EX    = rst_n ? shamt_field : 5'd0;
        alu_src_EX  = 2'd0;
        rdrt_EX     = 1'b0;
        regsel_EX   = 2'd0;
        regwrite_EX = 1'b0;
        enhilo_EX   = 1'b0;
        pc_src_EX   = 2'd0;
        stall_FETCH = 1'b0;
        gpio_we     = 1'b0;
        squash_nxt  = (squash_cnt != 2'd0) ? squash_cnt - 2'd1 : 2'd0;
        busy_nxt    = (busy_cnt != 4'd0) ? busy_cnt - 4'd1 : 4'd0;

        if (decode_en) begin
            case (opcode)
                OPC_SPECIAL: begin
                    case (funct)
                        FN_ADD: regwrite_EX = 1'b1;
                        FN_MULT, FN_MULTU: begin
                            if (hilo_busy) begin
                                stall_FETCH = 1'b1;
                            end else begin
                                enhilo_EX = 1'b1;
                                busy_nxt  = BUSY_LOAD;
                            end
                        end
                        FN_MFHI, FN_MFLO: begin
                            if (hilo_busy) begin
                                stall_FETCH = 1'b1;
                            end else begin
                                regwrite_EX = 1'b1;
                                regsel_EX   = (funct == FN_MFHI) ? 2'd1 : 2'd2;
                            end
                        end
                        FN_SRL: gpio_we = (shamt_field == 5'd0);
`ifdef EX_CTRL_JUMP_EN
                        FN_JR: begin
                            pc_src_EX   = 2'd2;
                            stall_FETCH = 1'b1;
                            squash_nxt  = SHADOW_LOAD;
                        end
`endif
                        default: ;
                    endcase
                end
                OPC_ADDI, OPC_ADDIU: begin
                    regwrite_EX = 1'b1;
                    alu_src_EX  = 2'd1;
                    rdrt_EX     = 1'b1;
                end
                OPC_LUI: begin
                    regwrite_EX = 1'b1;
                    alu_src_EX  = 2'd1;
                    shamt_EX    = 5'd16;
                    op_EX       = ALU_SLL;
                    rdrt_EX     = 1'b1;
                end
                OPC_ORI: begin
                    regwrite_EX = 1'b1;
                    alu_src_EX  = 2'd2;
                    op_EX       = ALU_OR;
                    rdrt_EX     = 1'b1;
                end
                OPC_BNE: begin
                    op_EX = ALU_SUB;
                    if (!zero_EX) begin
                        pc_src_EX   = 2'd1;
                        stall_FETCH = 1'b1;
                        squash_nxt  = SHADOW_LOAD;
                    end
                end
`ifdef EX_CTRL_JUMP_EN
                OPC_J, OPC_JAL: begin
                    pc_src_EX   = 2'd2;
                    stall_FETCH = 1'b1;
                    squash_nxt  = SHADOW_LOAD;
                    regwrite_EX = (opcode == OPC_JAL);
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_stage_ctrl.sv
// Randomized and directed bench for ex_stage_ctrl against a cycle-time model.
module tb_ex_stage_ctrl;

    localparam int MULT_LATENCY  = 4;
    localparam int BRANCH_SHADOW = 1;
    localparam int ALU_OP_W      = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_EX = 1'b0;
    logic        zero_EX = 1'b0;
    logic [31:0] instruction_EX = 32'd0;
    logic [ALU_OP_W-1:0] op_EX;
    logic [4:0]  shamt_EX;
    logic [1:0]  alu_src_EX, regsel_EX, pc_src_EX;
    logic        rdrt_EX, regwrite_EX, enhilo_EX, stall_FETCH, gpio_we, hilo_busy;

    ex_stage_ctrl #(
        .MULT_LATENCY(MULT_LATENCY), .BRANCH_SHADOW(BRANCH_SHADOW), .ALU_OP_W(ALU_OP_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .valid_EX(valid_EX), .instruction_EX(instruction_EX),
        .zero_EX(zero_EX), .op_EX(op_EX), .shamt_EX(shamt_EX), .alu_src_EX(alu_src_EX),
        .rdrt_EX(rdrt_EX), .regsel_EX(regsel_EX), .regwrite_EX(regwrite_EX),
        .enhilo_EX(enhilo_EX), .pc_src_EX(pc_src_EX), .stall_FETCH(stall_FETCH),
        .gpio_we(gpio_we), .hilo_busy(hilo_busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] op;
        logic [4:0] shamt;
        logic [1:0] alu_src;
        logic       rdrt;
        logic [1:0] regsel;
        logic       regwrite;
        logic       enhilo;
        logic [1:0] pc_src;
        logic       stall;
        logic       gpio;
        logic       busy;
    } out_t;

    out_t obs, exp_o, rst_o;
    assign obs = {op_EX, shamt_EX, alu_src_EX, rdrt_EX, regsel_EX, regwrite_EX,
                  enhilo_EX, pc_src_EX, stall_FETCH, gpio_we, hilo_busy};

    int vectors = 0;
    int errors  = 0;

    // Model state in absolute cycle numbers: HI/LO usable from hilo_ready on,
    // slots up to and including squash_last are squashed.
    int cyc = 0;
    int hilo_ready = 0;
    int squash_last = -1;

    function automatic logic [31:0] rt_ins(input logic [5:0] fn, input logic [4:0] sh);
        return {6'd0, 15'($urandom), sh, fn};
    endfunction

    function automatic logic [31:0] it_ins(input logic [5:0] opc);
        return {opc, 26'($urandom)};
    endfunction

    function automatic out_t model_eval(input logic [31:0] ins, input logic v, input logic z);
        out_t e;
        logic busy;
        logic [5:0] opc, fn;
        opc = ins[31:26];
        fn  = ins[5:0];
        busy = (cyc < hilo_ready);
        e = '0;
        e.op = 4'b0100;
        e.shamt = ins[10:6];
        e.busy = busy;
        if (!v || cyc <= squash_last) return e;
        if (opc == 6'd0) begin
            if (fn == 6'b100000) e.regwrite = 1'b1;
            else if (fn == 6'b011000 || fn == 6'b011001) begin
                if (busy) e.stall = 1'b1; else e.enhilo = 1'b1;
            end else if (fn == 6'b010000 || fn == 6'b010010) begin
                if (busy) e.stall = 1'b1;
                else begin
                    e.regwrite = 1'b1;
                    e.regsel = (fn == 6'b010000) ? 2'd1 : 2'd2;
                end
            end else if (fn == 6'b000010) e.gpio = (ins[10:6] == 5'd0);
`ifdef EX_CTRL_JUMP_EN
            else if (fn == 6'b001000) begin e.pc_src = 2'd2; e.stall = 1'b1; end
`endif
        end else if (opc == 6'b001000 || opc == 6'b001001) begin
            e.regwrite = 1'b1; e.alu_src = 2'd1; e.rdrt = 1'b1;
        end else if (opc == 6'b001111) begin
            e.regwrite = 1'b1; e.alu_src = 2'd1; e.rdrt = 1'b1; e.shamt = 5'd16; e.op = 4'b1000;
        end else if (opc == 6'b001101) begin
            e.regwrite = 1'b1; e.alu_src = 2'd2; e.rdrt = 1'b1; e.op = 4'b0001;
        end else if (opc == 6'b000101) begin
            e.op = 4'b0101;
            if (!z) begin e.pc_src = 2'd1; e.stall = 1'b1; end
        end
`ifdef EX_CTRL_JUMP_EN
        else if (opc == 6'b000010 || opc == 6'b000011) begin
            e.pc_src = 2'd2; e.stall = 1'b1; e.regwrite = (opc == 6'b000011);
        end
`endif
        return e;
    endfunction

    function automatic void model_commit(input logic [31:0] ins, input logic v, input logic z);
        logic [5:0] opc, fn;
        opc = ins[31:26];
        fn  = ins[5:0];
        if (!v || cyc <= squash_last) return;
        if (opc == 6'd0 && (fn == 6'b011000 || fn == 6'b011001) && cyc >= hilo_ready)
            hilo_ready = cyc + MULT_LATENCY;
        if (opc == 6'b000101 && !z) squash_last = cyc + BRANCH_SHADOW;
`ifdef EX_CTRL_JUMP_EN
        if (opc == 6'b000010 || opc == 6'b000011 || (opc == 6'd0 && fn == 6'b001000))
            squash_last = cyc + BRANCH_SHADOW;
`endif
    endfunction

    task automatic drive(input logic [31:0] ins, input logic v, input logic z);
        instruction_EX = ins;
        valid_EX = v;
        zero_EX = z;
        #4;
    endtask

    task automatic next_cycle();
        model_commit(instruction_EX, valid_EX, zero_EX);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(32'd0, 1'b0, 1'b0);
            next_cycle();
        end
    endtask

    task automatic test_reset();
        rst_o = '0;
        rst_o.op = 4'b0100;
        rst_n = 1'b0;
        instruction_EX = {6'b001111, 26'h1234567};
        valid_EX = 1'b1;
        #3;
        vectors++;
        if (obs !== rst_o) begin
            errors++; $display("FAIL reset_initial: got %h want %h", obs, rst_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive(rt_ins(6'b011000, 5'd0), 1'b1, 1'b0);
        exp_o = model_eval(instruction_EX, valid_EX, zero_EX);
        vectors++;
        if (obs !== exp_o) begin
            errors++; $display("FAIL reset_mult_issue: got %h want %h", obs, exp_o);
        end
        next_cycle();
        drive(rt_ins(6'b010010, 5'd3), 1'b1, 1'b0);
        exp_o = model_eval(instruction_EX, valid_EX, zero_EX);
        vectors++;
        if (obs !== exp_o) begin
            errors++; $display("FAIL reset_mflo_stall: got %h want %h", obs, exp_o);
        end
        #1;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (obs !== rst_o) begin
            errors++; $display("FAIL reset_midrun: got %h want %h", obs, rst_o);
        end
        hilo_ready = 0;
        squash_last = -1;
        #1;
        rst_n = 1'b1;
        #1;
        vectors++;
        if (hilo_busy !== 1'b0) begin
            errors++; $display("FAIL reset_release_busy: got %b want 0", hilo_busy);
        end
        next_cycle();
        drive(rt_ins(6'b010010, 5'd0), 1'b1, 1'b0);
        vectors++;
        if ({regwrite_EX, regsel_EX, stall_FETCH} !== 4'b1100) begin
            errors++; $display("FAIL reset_first_decode: got %b want 1100",
                               {regwrite_EX, regsel_EX, stall_FETCH});
        end
        next_cycle();
    endtask

    task automatic test_decode();
        logic [31:0] tbl [0:8];
        tbl[0] = rt_ins(6'b100000, 5'd7);
        tbl[1] = it_ins(6'b001000);
        tbl[2] = it_ins(6'b001001);
        tbl[3] = it_ins(6'b001111);
        tbl[4] = it_ins(6'b001101);
        tbl[5] = rt_ins(6'b000010, 5'd0);
        tbl[6] = rt_ins(6'b000010, 5'd9);
        tbl[7] = rt_ins(6'b010000, 5'd2);
        tbl[8] = it_ins(6'b111111);
        idle(6);
        for (int i = 0; i < 9; i++) begin
            drive(tbl[i], 1'b1, 1'($urandom));
            exp_o = model_eval(instruction_EX, valid_EX, zero_EX);
            vectors++;
            if (obs !== exp_o) begin
                errors++; $display("FAIL decode_%0d: got %h want %h", i, obs, exp_o);
            end
            if (i == 3) begin
                vectors++;
                if ({op_EX, shamt_EX} !== {4'b1000, 5'd16}) begin
                    errors++; $display("FAIL decode_lui: got %h want %h", {op_EX, shamt_EX}, {4'b1000, 5'd16});
                end
            end
            if (i == 5) begin
                vectors++;
                if ({gpio_we, regwrite_EX} !== 2'b10) begin
                    errors++; $display("FAIL decode_srl_gpio: got %b want 10", {gpio_we, regwrite_EX});
                end
            end
            next_cycle();
        end
        drive(tbl[0], 1'b0, 1'b0);
        vectors++;
        if (regwrite_EX !== 1'b0) begin
            errors++; $display("FAIL decode_invalid: got %b want 0", regwrite_EX);
        end
        next_cycle();
    endtask

    task automatic test_branch();
        idle(4);
        drive(it_ins(6'b000101), 1'b1, 1'b0);
        vectors++;
        if ({op_EX, pc_src_EX, stall_FETCH} !== {4'b0101, 2'd1, 1'b1}) begin
            errors++; $display("FAIL branch_taken: got %h want %h", {op_EX, pc_src_EX, stall_FETCH}, {4'b0101, 2'd1, 1'b1});
        end
        next_cycle();
        drive(rt_ins(6'b100000, 5'd0), 1'b1, 1'b0);
        vectors++;
        if (regwrite_EX !== 1'b0) begin
            errors++; $display("FAIL branch_shadow_squash: got %b want 0", regwrite_EX);
        end
        next_cycle();
        drive(rt_ins(6'b100000, 5'd0), 1'b1, 1'b0);
        vectors++;
        if (regwrite_EX !== 1'b1) begin
            errors++; $display("FAIL branch_after_shadow: got %b want 1", regwrite_EX);
        end
        next_cycle();
        drive(it_ins(6'b000101), 1'b1, 1'b1);
        vectors++;
        if ({pc_src_EX, stall_FETCH} !== 3'b000) begin
            errors++; $display("FAIL branch_not_taken: got %b want 000", {pc_src_EX, stall_FETCH});
        end
        next_cycle();
        drive(rt_ins(6'b100000, 5'd0), 1'b1, 1'b0);
        vectors++;
        if (regwrite_EX !== 1'b1) begin
            errors++; $display("FAIL branch_no_squash: got %b want 1", regwrite_EX);
        end
        next_cycle();
    endtask

    task automatic test_mult_interlock();
        idle(4);
        drive(rt_ins(6'b011001, 5'd0), 1'b1, 1'b0);
        vectors++;
        if ({enhilo_EX, stall_FETCH} !== 2'b10) begin
            errors++; $display("FAIL mult_issue: got %b want 10", {enhilo_EX, stall_FETCH});
        end
        next_cycle();
        for (int k = 1; k <= 4; k++) begin
            drive(rt_ins(6'b010010, 5'd0), 1'b1, 1'b0);
            vectors++;
            if (k < 4) begin
                if ({stall_FETCH, regwrite_EX, hilo_busy} !== 3'b101) begin
                    errors++; $display("FAIL mult_stall_%0d: got %b want 101", k, {stall_FETCH, regwrite_EX, hilo_busy});
                end
            end else if ({stall_FETCH, regwrite_EX, regsel_EX, hilo_busy} !== 5'b01100) begin
                errors++; $display("FAIL mult_mflo_issue: got %b want 01100", {stall_FETCH, regwrite_EX, regsel_EX, hilo_busy});
            end
            next_cycle();
        end
    endtask

    task automatic test_back_to_back();
        int pulses;
        idle(4);
        drive(rt_ins(6'b011000, 5'd0), 1'b1, 1'b0);
        vectors++;
        if (enhilo_EX !== 1'b1) begin
            errors++; $display("FAIL b2b_first: got %b want 1", enhilo_EX);
        end
        next_cycle();
        pulses = 0;
        for (int k = 1; k <= 6; k++) begin
            if (k <= 4) drive(rt_ins(6'b011000, 5'd0), 1'b1, 1'b0);
            else drive(32'd0, 1'b1, 1'b0);
            if (enhilo_EX === 1'b1) pulses++;
            vectors++;
            if (k <= 4 && {enhilo_EX, stall_FETCH} !== ((k == 4) ? 2'b10 : 2'b01)) begin
                errors++; $display("FAIL b2b_slot_%0d: got %b", k, {enhilo_EX, stall_FETCH});
            end else if (k > 4 && hilo_busy !== 1'b1) begin
                errors++; $display("FAIL b2b_busy_%0d: got %b want 1", k, hilo_busy);
            end
            next_cycle();
        end
        vectors++;
        if (pulses != 1) begin
            errors++; $display("FAIL b2b_pulse_count: got %0d want 1", pulses);
        end
    endtask

    task automatic test_jump();
        logic [31:0] ins;
        idle(6);
        ins = it_ins(6'b000010);
        drive(ins, 1'b1, 1'b0);
        exp_o = '0;
        exp_o.op = 4'b0100;
        exp_o.shamt = ins[10:6];
`ifdef EX_CTRL_JUMP_EN
        exp_o.pc_src = 2'd2;
        exp_o.stall = 1'b1;
`endif
        vectors++;
        if (obs !== exp_o) begin
            errors++; $display("FAIL jump_j: got %h want %h", obs, exp_o);
        end
        next_cycle();
        drive(rt_ins(6'b100000, 5'd0), 1'b1, 1'b0);
        vectors++;
`ifdef EX_CTRL_JUMP_EN
        if (regwrite_EX !== 1'b0) begin
            errors++; $display("FAIL jump_shadow: got %b want 0", regwrite_EX);
        end
`else
        if (regwrite_EX !== 1'b1) begin
            errors++; $display("FAIL jump_no_shadow: got %b want 1", regwrite_EX);
        end
`endif
        next_cycle();
    endtask

    task automatic test_random();
        logic [31:0] ins;
        logic hold;
        hold = 1'b0;
        ins = 32'd0;
        idle(4);
        for (int n = 0; n < 800; n++) begin
            if (!hold) begin
                case ($urandom_range(0, 14))
                    0:  ins = rt_ins(6'b100000, 5'($urandom));
                    1:  ins = it_ins(6'b001000);
                    2:  ins = it_ins(6'b001001);
                    3:  ins = it_ins(6'b001111);
                    4:  ins = it_ins(6'b001101);
                    5:  ins = rt_ins(6'b011000, 5'($urandom));
                    6:  ins = rt_ins(6'b011001, 5'($urandom));
                    7:  ins = rt_ins(6'b010000, 5'($urandom));
                    8:  ins = rt_ins(6'b010010, 5'($urandom));
                    9:  ins = it_ins(6'b000101);
                    10: ins = rt_ins(6'b000010, ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom));
                    11: ins = it_ins(6'b000010);
                    12: ins = it_ins(6'b000011);
                    13: ins = rt_ins(6'b001000, 5'($urandom));
                    default: ins = $urandom;
                endcase
            end
            drive(ins, ($urandom_range(0, 7) != 0) || hold, 1'($urandom));
            exp_o = model_eval(instruction_EX, valid_EX, zero_EX);
            vectors++;
            if (obs !== exp_o) begin
                errors++; $display("FAIL random_%0d: ins %h got %h want %h", n, ins, obs, exp_o);
            end
            hold = exp_o.stall && (exp_o.pc_src == 2'd0);
            next_cycle();
        end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_branch();
        test_mult_interlock();
        test_back_to_back();
        test_jump();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
